control_multicycle: RTL and testbench
=====================================

Name: control_multicycle

Overview:
Multicycle control FSM for the RV64I core. It is the successor to the single-cycle decoder: it sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the same datapath selects as multi-cycle strobes. It stalls on a memory ready handshake, detects memory timeouts, and is parametrised for RV64/RV32 opcode sets. It sits between the instruction/data memory interface and the shared ALU/regfile datapath.

Parameters:
TIMEOUT_W, 4, width of the memory wait counter; timeout fires after 2^TIMEOUT_W-1 consecutive cycles with mem_ready low.
RV32_ONLY, 0, 1 = OP_IMM_32 (0011011) and OP_32 (0111011) are illegal.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
inst_opcode  in  7  opcode bits [6:0] from memory read data; valid when mem_ready is high in FETCH
mem_ready  in  1  memory completes the current access this cycle
inst_mem_read  out  1  instruction fetch request
ir_write_enable  out  1  latch instruction register
pc_write_enable  out  1  unconditional PC write
branch_enable  out  1  conditional PC write; the datapath ANDs it with the compare result
data_mem_read_enable  out  1  load request
data_mem_write_enable  out  1  store request
regfile_write_enable  out  1  rd write
mem_to_reg_sel  out  2  00 ALUOut, 01 mem data, 10 saved PC+4
alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded, 11 branch compare
alu_sel_src_a  out  2  00 rs1, 01 PC, 10 zero, 11 old PC
alu_sel_src_b  out  2  00 rs2, 01 imm, 10 constant 4
pc_src_sel  out  1  0 ALU result, 1 ALUOut register
illegal_inst  out  1  unsupported opcode detected
mem_fault  out  1  sticky memory timeout flag
state  out  3  current state, for debug

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to FETCH; wait counter, latched opcode and mem_fault clear.
  - While rst is high, every output is forced to 0 except state=FETCH.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, FAULT=6.
- All outputs are Moore, decoded from state and the opcode latched at the FETCH exit.
- FETCH:
  - inst_mem_read=1, src_a=01, src_b=10, alu_op=00.
  - When mem_ready=1: ir_write_enable=1, pc_write_enable=1, opcode is latched, and the FSM goes to DECODE.
  - Otherwise it stays in FETCH.
- DECODE:
  - src_a=11, src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state is EXEC for supported opcodes.
  - For unsupported opcodes, see Optional Feature.
- EXEC, by opcode:
  - LOAD/STORE: src_a=00, src_b=01, alu_op=00; next MEM.
  - OP_IMM/OP_IMM_32: src_b=01, alu_op=10; next WB.
  - OP/OP_32: src_b=00, alu_op=10; next WB.
  - LUI: src_a=10, src_b=01; next WB.
  - AUIPC: src_a=11, src_b=01; next WB.
  - BRANCH: alu_op=11, branch_enable=1, pc_src_sel=1; next FETCH.
  - JAL: pc_write_enable=1, pc_src_sel=1; next WB.
  - JALR: src_a=00, src_b=01, pc_write_enable=1, pc_src_sel=0; next WB.
- MEM:
  - Load: data_mem_read_enable=1. Store: data_mem_write_enable=1.
  - Strobes are held until mem_ready=1.
  - On mem_ready, a store goes to FETCH and a load goes to WB.
- WB:
  - regfile_write_enable=1 for one cycle; next FETCH.
  - mem_to_reg_sel: 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- Cycle counts with zero wait states: branch 3; store, ALU ops, LUI, AUIPC, JAL and JALR 4; load 5.
- Each memory wait cycle adds 1.
- Wait counter:
  - Increments each FETCH/MEM cycle in which mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When it reaches 2^TIMEOUT_W-1, the FSM goes to FAULT.
- FAULT: mem_fault=1 and all strobes 0; the FSM stays there until rst.
- A mem_ready asserted in the same cycle the counter reaches its limit wins: the FSM proceeds normally.
- mem_ready is ignored outside FETCH/MEM.

Optional Feature:
CONTROL_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported opcode in DECODE goes to TRAP.
  - In TRAP, illegal_inst=1 and all strobes are 0; the FSM stays there until rst.
- Undefined:
  - An unsupported opcode in DECODE pulses illegal_inst for that cycle and goes to FETCH (NOP behaviour).
  - TRAP is unreachable.

Test Plan:
- Reset, then ADDI (0010011) with mem_ready=1 → states 0,1,2,4,0; pc_write_enable in cycle 1; regfile_write_enable only in cycle 4 with mem_to_reg_sel=00.
- LD (0000011) with data memory mem_ready low for 2 cycles → MEM lasts 3 cycles with data_mem_read_enable held; WB has mem_to_reg_sel=01; total 7 cycles.
- BEQ (1100011) → 3 cycles; branch_enable=1 only in EXEC; regfile_write_enable never 1.
- TIMEOUT_W=2 with mem_ready stuck 0 in FETCH → FAULT after 3 wait cycles; mem_fault=1 until rst; then a clean FETCH.
- RV32_ONLY=1 with opcode 0111011 → with the macro, TRAP with illegal_inst held; without it, a one-cycle illegal_inst pulse and a return to FETCH.
- Assert rst during MEM of a store → the next state is FETCH, data_mem_write_enable drops in that same cycle, and mem_fault=0.

Source files
------------

// File: rtl/control_multicycle.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory timeout.
// Optional macro CONTROL_ILLEGAL_TRAP_EN: illegal opcodes trap instead of acting as NOPs.
module control_multicycle #(
    parameter int TIMEOUT_W = 4,
    parameter bit RV32_ONLY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] inst_opcode,
    input  logic       mem_ready,
    output logic       inst_mem_read,
    output logic       ir_write_enable,
    output logic       pc_write_enable,
    output logic       branch_enable,
    output logic       data_mem_read_enable,
    output logic       data_mem_write_enable,
    output logic       regfile_write_enable,
    output logic [1:0] mem_to_reg_sel,
    output logic [1:0] alu_op,
    output logic [1:0] alu_sel_src_a,
    output logic [1:0] alu_sel_src_b,
    output logic       pc_src_sel,
    output logic       illegal_inst,
    output logic       mem_fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_IMM32  = 7'b0011011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = WAIT_MAX - 1'b1;

    state_t               state_q, state_d;
    logic [6:0]           opcode_q, opcode_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 fault_q, fault_d;

    logic is_load, is_store, is_imm, is_imm32, is_op, is_op32;
    logic is_lui, is_auipc, is_branch, is_jal, is_jalr, supported;

    assign is_load   = (opcode_q == OPC_LOAD);
    assign is_store  = (opcode_q == OPC_STORE);
    assign is_imm    = (opcode_q == OPC_IMM);
    assign is_imm32  = (opcode_q == OPC_IMM32);
    assign is_op     = (opcode_q == OPC_OP);
    assign is_op32   = (opcode_q == OPC_OP32);
    assign is_lui    = (opcode_q == OPC_LUI);
    assign is_auipc  = (opcode_q == OPC_AUIPC);
    assign is_branch = (opcode_q == OPC_BRANCH);
    assign is_jal    = (opcode_q == OPC_JAL);
    assign is_jalr   = (opcode_q == OPC_JALR);

    assign supported = is_load | is_store | is_imm | is_op | is_lui
                     | is_auipc | is_branch | is_jal | is_jalr
                     | (!RV32_ONLY & (is_imm32 | is_op32));

    // State, latched opcode, wait counter and sticky fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            wait_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state sequencing; a timeout only fires when mem_ready is still low.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        wait_d   = wait_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    opcode_d = inst_opcode;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (supported) begin
                    state_d = S_EXEC;
                end else begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
        endcase
        if (mem_ready || (state_d != state_q)) begin
            wait_d = '0;
        end else if (state_q == S_FETCH || state_q == S_MEM) begin
            wait_d = wait_q + 1'b1;
        end
        fault_d = fault_q | (state_d == S_FAULT);
    end

    // Datapath strobes decoded from state and latched opcode; all low in reset.
    always_comb begin
        inst_mem_read         = 1'b0;
        ir_write_enable       = 1'b0;
        pc_write_enable       = 1'b0;
        branch_enable         = 1'b0;
        data_mem_read_enable  = 1'b0;
        data_mem_write_enable = 1'b0;
        regfile_write_enable  = 1'b0;
        mem_to_reg_sel        = 2'b00;
        alu_op                = 2'b00;
        alu_sel_src_a         = 2'b00;
        alu_sel_src_b         = 2'b00;
        pc_src_sel            = 1'b0;
        illegal_inst          = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    inst_mem_read   = 1'b1;
                    ir_write_enable = mem_ready;
                    pc_write_enable = mem_ready;
                    alu_sel_src_a   = 2'b01;
                    alu_sel_src_b   = 2'b10;
                end
                S_DECODE: begin
                    alu_sel_src_a = 2'b11;
                    alu_sel_src_b = 2'b01;
`ifndef CONTROL_ILLEGAL_TRAP_EN
                    illegal_inst  = !supported;
`endif
                end
                S_EXEC: begin
                    unique case (1'b1)
                        is_load, is_store: alu_sel_src_b = 2'b01;
                        is_imm, is_imm32: begin
                            alu_sel_src_b = 2'b01;
                            alu_op        = 2'b10;
                        end
                        is_op, is_op32: alu_op = 2'b10;
                        is_lui: begin
                            alu_sel_src_a = 2'b10;
                            alu_sel_src_b = 2'b01;
                        end
                        is_auipc: begin
                            alu_sel_src_a = 2'b11;
                            alu_sel_src_b = 2'b01;
                        end
                        is_branch: begin
                            alu_op        = 2'b11;
                            branch_enable = 1'b1;
                            pc_src_sel    = 1'b1;
                        end
                        is_jal: begin
                            pc_write_enable = 1'b1;
                            pc_src_sel      = 1'b1;
                        end
                        is_jalr: begin
                            alu_sel_src_b   = 2'b01;
                            pc_write_enable = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    data_mem_read_enable  = is_load;
                    data_mem_write_enable = is_store;
                end
                S_WB: begin
                    regfile_write_enable = 1'b1;
                    if (is_load) begin
                        mem_to_reg_sel = 2'b01;
                    end else if (is_jal || is_jalr) begin
                        mem_to_reg_sel = 2'b10;
                    end
                end
                S_TRAP:  illegal_inst = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_fault = fault_q & ~rst;
    assign state     = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_control_multicycle.sv
// Self-checking bench for control_multicycle (TIMEOUT_W=2, RV32_ONLY=1).
// Expected strobes come from a per-phase table of the instruction flow.
module tb_control_multicycle;

    localparam int TW   = 2;
    localparam bit RV32 = 1'b1;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] IMM    = 7'b0010011;
    localparam logic [6:0] IMM32  = 7'b0011011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP32   = 7'b0111011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_ready = 1'b0;
    logic [6:0] inst_opcode = '0;
    logic       inst_mem_read, ir_write_enable, pc_write_enable;
    logic       branch_enable, data_mem_read_enable, data_mem_write_enable;
    logic       regfile_write_enable, pc_src_sel, illegal_inst, mem_fault;
    logic [1:0] mem_to_reg_sel, alu_op, alu_sel_src_a, alu_sel_src_b;
    logic [2:0] state;
    logic [20:0] act;

    int n_checks = 0;
    int n_fail   = 0;

    control_multicycle #(.TIMEOUT_W(TW), .RV32_ONLY(RV32)) dut (
        .clk(clk), .rst(rst), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
        .inst_mem_read(inst_mem_read), .ir_write_enable(ir_write_enable),
        .pc_write_enable(pc_write_enable), .branch_enable(branch_enable),
        .data_mem_read_enable(data_mem_read_enable),
        .data_mem_write_enable(data_mem_write_enable),
        .regfile_write_enable(regfile_write_enable),
        .mem_to_reg_sel(mem_to_reg_sel), .alu_op(alu_op),
        .alu_sel_src_a(alu_sel_src_a), .alu_sel_src_b(alu_sel_src_b),
        .pc_src_sel(pc_src_sel), .illegal_inst(illegal_inst),
        .mem_fault(mem_fault), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {state, inst_mem_read, ir_write_enable, pc_write_enable,
                  branch_enable, data_mem_read_enable, data_mem_write_enable,
                  regfile_write_enable, mem_to_reg_sel, alu_op,
                  alu_sel_src_a, alu_sel_src_b, pc_src_sel, illegal_inst, mem_fault};

    function automatic bit legal(input logic [6:0] op);
        case (op)
            LOAD, STORE, IMM, OP, LUI, AUIPC, BRANCH, JAL, JALR: return 1'b1;
            IMM32, OP32: return !RV32;
            default: return 1'b0;
        endcase
    endfunction

    // Expected outputs for one cycle in phase st (0..6) of instruction op.
    function automatic logic [20:0] expect_vec(input int st, input logic [6:0] op,
                                               input logic rdy);
        logic [2:0] s;
        logic imr, irw, pcw, br, dmr, dmw, rfw, pcs, ill, flt;
        logic [1:0] m2r, alu, sa, sb;
        {imr, irw, pcw, br, dmr, dmw, rfw, pcs, ill, flt} = '0;
        {m2r, alu, sa, sb} = '0;
        s = 3'(st);
        case (st)
            0: begin imr = 1; irw = rdy; pcw = rdy; sa = 2'd1; sb = 2'd2; end
            1: begin
                sa = 2'd3; sb = 2'd1;
`ifndef CONTROL_ILLEGAL_TRAP_EN
                ill = !legal(op);
`endif
            end
            2: case (op)
                LOAD, STORE: sb = 2'd1;
                IMM, IMM32: begin sb = 2'd1; alu = 2'd2; end
                OP, OP32: alu = 2'd2;
                LUI: begin sa = 2'd2; sb = 2'd1; end
                AUIPC: begin sa = 2'd3; sb = 2'd1; end
                BRANCH: begin alu = 2'd3; br = 1; pcs = 1; end
                JAL: begin pcw = 1; pcs = 1; end
                JALR: begin sb = 2'd1; pcw = 1; end
                default: ;
            endcase
            3: begin dmr = (op == LOAD); dmw = (op == STORE); end
            4: begin
                rfw = 1;
                m2r = (op == LOAD) ? 2'd1 : ((op == JAL || op == JALR) ? 2'd2 : 2'd0);
            end
            5: ill = 1;
            6: flt = 1;
            default: ;
        endcase
        return {s, imr, irw, pcw, br, dmr, dmw, rfw, m2r, alu, sa, sb, pcs, ill, flt};
    endfunction

    task automatic cyc(input string name, input int st, input logic [6:0] drv,
                       input logic [6:0] op, input logic rdy);
        logic [20:0] exp;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = rdy;
        inst_opcode = drv;
        #1;
        exp = expect_vec(st, op, rdy);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: phase %0d got %b expected %b", name, st, act, exp);
        end
    endtask

    task automatic check_forced(input string name);
        n_checks++;
        if (act !== 21'd0) begin
            n_fail++;
            $display("FAIL %s: got %b expected all zero", name, act);
        end
    endtask

    // Leaves rst high; the next cyc releases it on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'($urandom);
        #1 check_forced("reset_forced");
        @(negedge clk);
        #1 check_forced("reset_hold");
    endtask

    task automatic run_inst(input string name, input logic [6:0] op,
                            input int sf, input int sm);
        for (int i = 0; i < sf; i++) cyc(name, 0, 7'($urandom), op, 1'b0);
        cyc(name, 0, op, op, 1'b1);
        cyc(name, 1, 7'($urandom), op, 1'($urandom));
        if (!legal(op)) begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 3; i++) cyc(name, 5, 7'($urandom), op, 1'($urandom));
            do_reset();
`endif
            return;
        end
        cyc(name, 2, 7'($urandom), op, 1'($urandom));
        if (op == LOAD || op == STORE) begin
            for (int i = 0; i < sm; i++) cyc(name, 3, 7'($urandom), op, 1'b0);
            cyc(name, 3, 7'($urandom), op, 1'b1);
        end
        if (op != BRANCH && op != STORE) cyc(name, 4, 7'($urandom), op, 1'($urandom));
    endtask

    task automatic test_reset();
        do_reset();
        cyc("reset_fetch", 0, 7'($urandom), IMM, 1'b0);
    endtask

    task automatic test_addi();
        do_reset();
        run_inst("addi", IMM, 0, 0);
        cyc("addi_next", 0, 7'($urandom), IMM, 1'b0);
    endtask

    task automatic test_load_stall();
        run_inst("ld_stall", LOAD, 0, 2);
    endtask

    task automatic test_branch();
        run_inst("beq", BRANCH, 1, 0);
    endtask

    task automatic test_illegal();
        run_inst("op32_illegal", OP32, 0, 0);
        run_inst("imm32_illegal", IMM32, 0, 0);
        run_inst("junk_illegal", 7'b1111111, 0, 0);
        run_inst("after_illegal", OP, 0, 0);
    endtask

    task automatic test_ready_wins();
        run_inst("ready_wins", LOAD, 2, 2);
        run_inst("ready_wins_st", STORE, 2, 2);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) cyc("to_fetch", 0, 7'($urandom), IMM, 1'b0);
        for (int i = 0; i < 4; i++) cyc("to_fault", 6, 7'($urandom), IMM, 1'($urandom));
        do_reset();
        cyc("to_clean", 0, 7'($urandom), IMM, 1'b0);
        run_inst("to_after", JAL, 0, 0);
        cyc(" to_mem_f", 0, LOAD, LOAD, 1'b1);
        cyc("to_mem_d", 1, 7'($urandom), LOAD, 1'b0);
        cyc("to_mem_e", 2, 7'($urandom), LOAD, 1'b0);
        for (int i = 0; i < 3; i++) cyc("to_mem", 3, 7'($urandom), LOAD, 1'b0);
        for (int i = 0; i < 3; i++) cyc("to_mem_fault", 6, 7'($urandom), LOAD, 1'($urandom));
        do_reset();
    endtask

    task automatic test_reset_in_mem();
        cyc("rim_f", 0, STORE, STORE, 1'b1);
        cyc("rim_d", 1, 7'($urandom), STORE, 1'b0);
        cyc("rim_e", 2, 7'($urandom), STORE, 1'b0);
        cyc("rim_m", 3, 7'($urandom), STORE, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1 check_forced("rim_store_drop");
        cyc("rim_fetch", 0, 7'($urandom), STORE, 1'b0);
        run_inst("rim_after", AUIPC, 1, 0);
    endtask

    task automatic test_random();
        logic [6:0] tbl [11];
        logic [6:0] op;
        tbl = '{LOAD, STORE, IMM, IMM32, OP, OP32, LUI, AUIPC, BRANCH, JAL, JALR};
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 10)];
            run_inst("random", op, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_stall();
        test_branch();
        test_illegal();
        test_ready_wins();
        test_timeout();
        test_reset_in_mem();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
